// File: rtl/hart_mem_arbiter.sv
// hart_mem_arbiter: round-robin share of one data-memory port between the barrel harts.
// Latency: request seen in IDLE -> mem_req_valid next cycle; matching memory response -> hart_rsp_valid next cycle.
// Backpressure: the request is held stable while mem_req_ready is low; one transaction is outstanding at a time.
//
// Ports: clk/rst_n (synchronous, active-low reset); hart_req_* level requests from each hart,
// hart_rsp_* one-cycle response pulse; blocked[] to barrel_sched; mem_req_*/mem_rsp_* the
// single memory port, with a 1-bit tag that toggles per accepted request.
// Optional feature: define MEM_ARB_TIMEOUT_EN to end a WAIT after TIMEOUT_CYC cycles with hart_rsp_err=1.

`ifndef HART_NUM
`define HART_NUM 2
`endif

module hart_mem_arbiter #(
  parameter int HART_NUM    = `HART_NUM,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [HART_NUM-1:0]          hart_req_valid,
  input  logic [HART_NUM-1:0]          hart_req_we,
  input  logic [HART_NUM*ADDR_W-1:0]   hart_req_addr,
  input  logic [HART_NUM*DATA_W-1:0]   hart_req_wdata,
  input  logic [HART_NUM*DATA_W/8-1:0] hart_req_wstrb,
  output logic [HART_NUM-1:0]          hart_rsp_valid,
  output logic [DATA_W-1:0]            hart_rsp_rdata,
  output logic                         hart_rsp_err,
  output logic [HART_NUM-1:0]          blocked,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic                         mem_req_we,
  output logic [ADDR_W-1:0]            mem_req_addr,
  output logic [DATA_W-1:0]            mem_req_wdata,
  output logic [DATA_W/8-1:0]          mem_req_wstrb,
  output logic                         mem_req_tag,
  input  logic                         mem_rsp_valid,
  input  logic                         mem_rsp_tag,
  input  logic [DATA_W-1:0]            mem_rsp_rdata
);

  localparam int WIN_W = (HART_NUM > 1) ? $clog2(HART_NUM) : 1;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t            state;
  logic [WIN_W-1:0]  last_grant;
  logic [WIN_W-1:0]  winner_q;
  logic [WIN_W-1:0]  win_d;
  logic              tag_q;        // tag of the transaction currently in flight
  logic [DATA_W-1:0] rdata_q;
  logic              rsp_match;
  logic [HART_NUM-1:0] rsp_onehot;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_wstrb;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;
  assign hart_rsp_err = err_q;
`else
  assign hart_rsp_err = 1'b0;
`endif

  // Responses carrying a stale tag never match, whatever state we are in.
  assign rsp_match      = mem_rsp_valid && (mem_rsp_tag == tag_q);
  assign hart_rsp_rdata = rdata_q;
  assign blocked        = hart_req_valid & ~hart_rsp_valid;

  // Round-robin: scan starting one past the last grant, wrapping modulo HART_NUM.
  always_comb begin
    logic             found;
    logic [WIN_W-1:0] idx;
    found = 1'b0;
    win_d = last_grant;
    idx   = '0;
    for (int i = 1; i <= HART_NUM; i++) begin
      idx = WIN_W'((int'(last_grant) + i) % HART_NUM);
      if (!found && hart_req_valid[idx]) begin
        found = 1'b1;
        win_d = idx;
      end
    end
  end

  // Field mux for the hart about to be granted.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int h = 0; h < HART_NUM; h++) begin
      if (win_d == WIN_W'(h)) begin
        sel_we    = hart_req_we[h];
        sel_addr  = hart_req_addr[h*ADDR_W +: ADDR_W];
        sel_wdata = hart_req_wdata[h*DATA_W +: DATA_W];
        sel_wstrb = hart_req_wstrb[h*STRB_W +: STRB_W];
      end
    end
  end

  always_comb begin
    rsp_onehot           = '0;
    rsp_onehot[winner_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      last_grant     <= WIN_W'(HART_NUM - 1);
      winner_q       <= '0;
      tag_q          <= 1'b0;
      rdata_q        <= '0;
      hart_rsp_valid <= '0;
      mem_req_valid  <= 1'b0;
      mem_req_we     <= 1'b0;
      mem_req_addr   <= '0;
      mem_req_wdata  <= '0;
      mem_req_wstrb  <= '0;
      mem_req_tag    <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_cnt       <= '0;
      err_q          <= 1'b0;
`endif
    end else begin
      hart_rsp_valid <= '0;
      case (state)
        S_IDLE: begin
          if (|hart_req_valid) begin
            winner_q      <= win_d;
            last_grant    <= win_d;
            mem_req_we    <= sel_we;
            mem_req_addr  <= sel_addr;
            mem_req_wdata <= sel_wdata;
            mem_req_wstrb <= sel_wstrb;
            // Present the tag this transaction will own once accepted.
            mem_req_tag   <= ~tag_q;
            mem_req_valid <= 1'b1;
            state         <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            tag_q         <= mem_req_tag;
            state         <= S_WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt      <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (rsp_match) begin
            rdata_q        <= mem_rsp_rdata;
            hart_rsp_valid <= rsp_onehot;
            state          <= S_RESP;
`ifdef MEM_ARB_TIMEOUT_EN
            err_q          <= 1'b0;
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            rdata_q        <= '0;
            err_q          <= 1'b1;
            hart_rsp_valid <= rsp_onehot;
            state          <= S_RESP;
          end else begin
            wait_cnt       <= wait_cnt + 1'b1;
`endif
          end
        end
        S_RESP: begin
          // No arbitration here, so the responding hart's still-high request is not re-granted.
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hart_mem_arbiter.sv
// tb_hart_mem_arbiter: directed and randomized checks of hart_mem_arbiter against a round-robin model.
// Latency: checks grant, request and response cycle timing.
// Backpressure: drives mem_req_ready low for several cycles and checks request stability.

`ifndef HART_NUM
`define HART_NUM 2
`endif

module tb_hart_mem_arbiter;

  localparam int NH = `HART_NUM;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NH-1:0]    req_v;
  logic [NH-1:0]    req_we;
  logic [AW-1:0]    r_addr [NH];
  logic [DW-1:0]    r_wdata[NH];
  logic [SW-1:0]    r_wstrb[NH];
  logic [NH*AW-1:0] req_addr_p;
  logic [NH*DW-1:0] req_wdata_p;
  logic [NH*SW-1:0] req_wstrb_p;

  always_comb begin
    req_addr_p  = '0;
    req_wdata_p = '0;
    req_wstrb_p = '0;
    for (int h = 0; h < NH; h++) begin
      req_addr_p[h*AW +: AW]  = r_addr[h];
      req_wdata_p[h*DW +: DW] = r_wdata[h];
      req_wstrb_p[h*SW +: SW] = r_wstrb[h];
    end
  end

  logic [NH-1:0] hart_rsp_valid;
  logic [DW-1:0] hart_rsp_rdata;
  logic          hart_rsp_err;
  logic [NH-1:0] blocked;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic          mem_req_we;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic [SW-1:0] mem_req_wstrb;
  logic          mem_req_tag;
  logic          mem_rsp_valid;
  logic          mem_rsp_tag;
  logic [DW-1:0] mem_rsp_rdata;

  hart_mem_arbiter #(
    .HART_NUM(NH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .hart_req_valid(req_v), .hart_req_we(req_we), .hart_req_addr(req_addr_p),
    .hart_req_wdata(req_wdata_p), .hart_req_wstrb(req_wstrb_p),
    .hart_rsp_valid(hart_rsp_valid), .hart_rsp_rdata(hart_rsp_rdata), .hart_rsp_err(hart_rsp_err),
    .blocked(blocked),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_req_tag(mem_req_tag),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_tag(mem_rsp_tag), .mem_rsp_rdata(mem_rsp_rdata)
  );

  int   checks = 0;
  int   errors = 0;
  int   m_last;     // model: last granted hart
  logic m_tag;      // model: tag of the latest accepted request

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requester after the last grant, modulo the hart count.
  function automatic int pick(input logic [NH-1:0] v, input int last);
    for (int i = 1; i <= NH; i++)
      if (v[(last + i) % NH]) return (last + i) % NH;
    return -1;
  endfunction

  task automatic rand_hart(input int h);
    req_v[h]   = 1'($urandom_range(0, 1));
    req_we[h]  = 1'($urandom_range(0, 1));
    r_addr[h]  = $urandom;
    r_wdata[h] = $urandom;
    r_wstrb[h] = SW'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_hart_rsp_valid", hart_rsp_valid, 0);
    chk("rst_mem_req_tag", mem_req_tag, 0);
    chk("rst_rsp_fields", {hart_rsp_err, hart_rsp_rdata}, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    rst_n  = 1'b1;
    m_last = NH - 1;
    m_tag  = 1'b0;
  endtask

  // mode 0: normal; 1: wrong-tag response first, correct one 3 cycles later; 2: no response (timeout).
  task automatic do_txn(input int mode, input int ready_dly, input int rsp_dly,
                        input logic [DW-1:0] rd, input logic drop, output int w);
    int n;
    n = 0;
    while (mem_req_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("grant_latency", n, 1);
    w      = pick(req_v, m_last);
    m_last = w;
    m_tag  = ~m_tag;
    chk("req_fields", {mem_req_addr, mem_req_wdata}, {r_addr[w], r_wdata[w]});
    chk("req_we_strb", {mem_req_we, mem_req_wstrb}, {req_we[w], r_wstrb[w]});
    chk("req_tag", mem_req_tag, m_tag);
    repeat (ready_dly) begin
      mem_req_ready = 1'b0;
      @(negedge clk);
      chk("req_hold_vld", mem_req_valid, 1);
      chk("req_hold_dat", {mem_req_addr, mem_req_wdata}, {r_addr[w], r_wdata[w]});
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("req_accept_drop", mem_req_valid, 0);
    if (mode == 2) begin
      n = 0;
      while (hart_rsp_valid == '0 && n < 300) begin
        @(negedge clk);
        n++;
      end
      chk("timeout_cycles", n, TO);
      chk("timeout_err", hart_rsp_err, 1);
      chk("timeout_rdata", hart_rsp_rdata, 0);
      chk("timeout_onehot", hart_rsp_valid, NH'(1) << w);
      // Late response lands outside WAIT and must be ignored.
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = m_tag;
      mem_rsp_rdata = rd;
    end else begin
      if (mode == 1) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = ~m_tag;
        mem_rsp_rdata = ~rd;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("stale_dropped", hart_rsp_valid, 0);
        repeat (2) begin
          @(negedge clk);
          chk("stale_no_rsp", hart_rsp_valid, 0);
        end
      end else begin
        repeat (rsp_dly) begin
          @(negedge clk);
          chk("wait_no_rsp", hart_rsp_valid, 0);
          chk("wait_blocked", blocked, req_v);
        end
      end
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = m_tag;
      mem_rsp_rdata = rd;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      chk("rsp_onehot", hart_rsp_valid, NH'(1) << w);
      chk("rsp_rdata", hart_rsp_rdata, rd);
      chk("rsp_err", hart_rsp_err, 0);
      chk("rsp_blocked", blocked, req_v & ~(NH'(1) << w));
    end
    if (drop) req_v[w] = 1'b0;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("rsp_pulse_end", hart_rsp_valid, 0);
    chk("idle_blocked", blocked, req_v);
  endtask

  initial begin
    int w;
    req_v = '0; req_we = '0;
    for (int h = 0; h < NH; h++) begin
      r_addr[h] = '0; r_wdata[h] = '0; r_wstrb[h] = '0;
    end
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_tag = 1'b0; mem_rsp_rdata = '0;

    // Reset mid-WAIT followed by a stale tag-1 response.
    do_reset();
    req_v[0] = 1'b1; r_addr[0] = 32'h40;
    repeat (2) @(negedge clk);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    req_v = '0;
    @(negedge clk);
    rst_n = 1'b1;
    m_last = NH - 1; m_tag = 1'b0;
    chk("midrst_req_valid", mem_req_valid, 0);
    mem_rsp_valid = 1'b1; mem_rsp_tag = 1'b1; mem_rsp_rdata = 32'h12345678;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("midrst_no_rsp", hart_rsp_valid, 0);
    @(negedge clk);
    chk("midrst_no_rsp2", hart_rsp_valid, 0);
    chk("midrst_idle", mem_req_valid, 0);

    // Single hart-0 load.
    do_reset();
    req_v[0] = 1'b1; req_we[0] = 1'b0; r_addr[0] = 32'h100; r_wstrb[0] = '1; r_wdata[0] = '0;
    #1 chk("load_blocked_pre", blocked, 1);
    do_txn(0, 0, 1, 32'hDEADBEEF, 1'b1, w);
    chk("load_blocked_post", blocked, 0);

    // Both harts requesting continuously: alternating grants and tags.
    do_reset();
    for (int h = 0; h < NH; h++) begin
      req_v[h] = 1'b1; req_we[h] = 1'(h); r_addr[h] = 32'h1000 + 32'(h * 16);
      r_wdata[h] = 32'hA0 + 32'(h); r_wstrb[h] = '1;
    end
    for (int t = 0; t < 4; t++) begin
      do_txn(0, 0, 0, 32'h5000 + 32'(t), 1'b0, w);
      chk("rr_order", w, t % NH);
    end
    req_v = '0;

    // Ready held low for 5 cycles.
    req_v[1] = 1'b1; r_addr[1] = 32'h2222; r_wdata[1] = 32'h3333;
    do_txn(0, 5, 0, 32'hCAFE0001, 1'b1, w);

    // Wrong-tag response, then the right one 3 cycles later.
    req_v[0] = 1'b1; r_addr[0] = 32'h4444;
    do_txn(1, 0, 0, 32'hBEEF0002, 1'b1, w);

`ifdef MEM_ARB_TIMEOUT_EN
    req_v[0] = 1'b1; r_addr[0] = 32'h8888;
    do_txn(2, 0, 0, 32'h77777777, 1'b1, w);
    repeat (2) @(negedge clk);
    chk("late_rsp_ignored", hart_rsp_valid, 0);
`endif

    // Randomized traffic.
    for (int h = 0; h < NH; h++) rand_hart(h);
    if (req_v == '0) req_v[0] = 1'b1;
    for (int t = 0; t < 24; t++) begin
      do_txn(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             $urandom, 1'b0, w);
      for (int h = 0; h < NH; h++)
        if (h == w || !req_v[h]) rand_hart(h);
      if (req_v == '0) req_v[$urandom_range(0, NH - 1)] = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
